pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Hazard and sequencing controller for the 5-stage pipeline (IF, RF, EX, MEM, WB).
//  Tracks the destination registers of in-flight instructions in its own scoreboard.
//  Generates stall, bubble and flush controls for the PC and pipeline registers, and
//  registered forwarding selects for the EX-stage ALU operand muxes.
//  Also provides a halt/drain FSM and saturating stall/flush performance counters.
// PARAMETERS
//  FORWARD_EN  1   1: forward from EX/MEM and MEM/WB; 0: interlock only (stall on any match)
//  CNT_W       16  width of each performance counter
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      asynchronous, active-low reset
//  rf_valid       in   1      RF stage holds a real instruction (not a bubble)
//  rf_rs, rf_rt   in   5 each source register fields of the RF-stage instruction
//  rf_use_rs/rt   in   1 each RF-stage instruction actually reads rs / rt
//  rf_wren        in   1      RF-stage instruction writes the register file
//  rf_dest        in   5      its destination (rd or rt, already muxed)
//  rf_memtoreg    in   1      RF-stage instruction is a load
//  ex_taken       in   1      instruction in EX is a taken branch/jump/jr; PC redirects this edge
//  halt_req       in   1      level request to stop fetching and drain the pipeline
//  pc_hold        out  1      hold PC
//  ifrf_hold      out  1      hold IF/RF register
//  ifrf_flush     out  1      load NOP into IF/RF register
//  rfex_bubble    out  1      load NOP (all write enables 0) into RF/EX register
//  fwd_a, fwd_b   out  2 each EX operand select: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
//  halted         out  1      pipeline drained and fetch stopped
//  stall_cnt      out  CNT_W  cycles in which load-use/interlock stall was asserted
//  flush_cnt      out  CNT_W  cycles in which ex_taken caused a flush
// BEHAVIOUR
//  Reset (reset=0, async): scoreboard invalid, fwd_a/fwd_b=00, counters=0, state RUN.
//   All outputs are 0 while reset is low.
//  Scoreboard: three slots SB_EX, SB_MEM, SB_WB, each {valid, dest, is_load}.
//   On each edge: SB_WB<=SB_MEM and SB_MEM<=SB_EX.
//   SB_EX<={rf_valid&rf_wren&~stall&~flush, rf_dest, rf_memtoreg}.
//   A slot with dest==0 never matches.
//  match(S,r) = S.valid & S.dest==r & r!=0. Check rs when rf_use_rs, rt when rf_use_rt.
//  FORWARD_EN=1: stall = rf_valid & (match on SB_EX with SB_EX.is_load) (load-use, 1 cycle).
//  FORWARD_EN=0: stall = rf_valid & (match on SB_EX or SB_MEM).
//  The register file is write-through, so an SB_WB match never needs action.
//  flush = ex_taken.
//  Priority: flush over stall; a stalled RF instruction is wrong-path and is discarded.
//  Outputs:
//   - flush: ifrf_flush=1, rfex_bubble=1, pc_hold=0.
//   - stall: pc_hold=1, ifrf_hold=1, rfex_bubble=1.
//   - otherwise: all 0, except halt states below.
//  Forwarding selects are registered, so they are valid while the instruction sits in EX.
//   On an edge with no stall/flush, for each operand:
//     01 if it matches SB_EX; else 10 if it matches SB_MEM; else 00.
//   On a stall/flush edge, or with FORWARD_EN=0, the selects load 00.
//  Halt FSM:
//   RUN -> DRAIN when halt_req=1.
//   DRAIN: pc_hold=1, ifrf_flush=1 (fetch stops, younger slots empty).
//     Goes to HALTED when SB_EX, SB_MEM and SB_WB are all invalid and rf_valid=0.
//   HALTED: halted=1, pc_hold=1, ifrf_flush=1.
//   HALTED -> RUN when halt_req=0. DRAIN -> RUN when halt_req=0 (aborts the drain).
//   ex_taken during DRAIN still flushes; the PC redirect is honoured since pc_hold is overridden by flush.
//  Counters: stall_cnt increments on each stall cycle; flush_cnt increments on each flush cycle.
//   Neither counts in DRAIN or HALTED. Both saturate at all-ones (no wrap).
//  Simultaneous load-use and ex_taken: flush only; stall_cnt does not increment.
// TESTING
//  1. Release reset with $3 dest of an add in SB_EX, then next instr reads $3 -> fwd_a=01 in its EX cycle, no stall.
//  2. lw $4 in EX, RF reads rt=$4 -> one cycle of pc_hold=ifrf_hold=rfex_bubble=1, stall_cnt=1; then fwd_b=10.
//  3. RF reads $0 while lw $0 is in EX -> no stall, fwd=00.
//  4. FORWARD_EN=0, add $5 followed by use of $5 -> exactly 2 stall cycles, stall_cnt=2.
//  5. Load-use and ex_taken in the same cycle -> ifrf_flush=rfex_bubble=1, pc_hold=0, flush_cnt=1, stall_cnt=0.
//  6. halt_req=1 with 3 instructions in flight -> halted=1 after the scoreboard empties (<=4 cycles);
//     drop halt_req -> RUN next cycle. Assert reset mid-DRAIN -> all outputs and counters 0 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: scoreboard-driven stall,
// flush and forwarding selects, halt/drain FSM and saturating perf counters.

// Per-operand comparator: does this source register hit the EX or MEM slot?
module pipeline_hazard_ctrl_opnd (
  input  logic       use_r,
  input  logic [4:0] r,
  input  logic       ex_vld,
  input  logic [4:0] ex_dest,
  input  logic       mem_vld,
  input  logic [4:0] mem_dest,
  output logic       hit_ex,
  output logic       hit_mem
);
  logic live;
  assign live    = use_r & (|r);
  assign hit_ex  = live & ex_vld  & (ex_dest  == r);
  assign hit_mem = live & mem_vld & (mem_dest == r);
endmodule

module pipeline_hazard_ctrl #(
  parameter int FORWARD_EN = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rf_valid,
  input  logic [4:0]       rf_rs,
  input  logic [4:0]       rf_rt,
  input  logic             rf_use_rs,
  input  logic             rf_use_rt,
  input  logic             rf_wren,
  input  logic [4:0]       rf_dest,
  input  logic             rf_memtoreg,
  input  logic             ex_taken,
  input  logic             halt_req,
  output logic             pc_hold,
  output logic             ifrf_hold,
  output logic             ifrf_flush,
  output logic             rfex_bubble,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int NUM_OPND = 2;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic       vld;
    logic [4:0] dest;
    logic       is_load;
  } sb_ex_t;

  state_t state;
  sb_ex_t sb_ex;
  logic       sb_mem_vld;
  logic [4:0] sb_mem_dest;
  // WB only matters for drain detection: the regfile is write-through.
  logic       sb_wb_vld;

  logic [NUM_OPND-1:0][4:0] src;
  logic [NUM_OPND-1:0]      src_use, hit_ex, hit_mem;

  assign src     = {rf_rt, rf_rs};
  assign src_use = {rf_use_rt, rf_use_rs};

  for (genvar g = 0; g < NUM_OPND; g++) begin : g_opnd
    pipeline_hazard_ctrl_opnd u_opnd (
      .use_r   (src_use[g]),
      .r       (src[g]),
      .ex_vld  (sb_ex.vld),
      .ex_dest (sb_ex.dest),
      .mem_vld (sb_mem_vld),
      .mem_dest(sb_mem_dest),
      .hit_ex  (hit_ex[g]),
      .hit_mem (hit_mem[g])
    );
  end

  logic load_use, interlock, stall_raw, flush, stall, draining, sb_empty;

  assign load_use  = sb_ex.is_load & (|hit_ex);
  assign interlock = (|hit_ex) | (|hit_mem);
  assign stall_raw = rf_valid & ((FORWARD_EN != 0) ? load_use : interlock);
  assign flush     = ex_taken;
  assign stall     = stall_raw & ~flush;
  assign draining  = (state != RUN);
  assign sb_empty  = ~sb_ex.vld & ~sb_mem_vld & ~sb_wb_vld;

  // A held RF instruction during drain must survive, so hold beats drain-flush.
  assign pc_hold     = reset & ~flush & (stall | draining);
  assign ifrf_hold   = reset & stall;
  assign ifrf_flush  = reset & (flush | (draining & ~stall));
  assign rfex_bubble = reset & (flush | stall);

  function automatic logic [1:0] fsel(input logic e, input logic m);
    return e ? 2'b01 : (m ? 2'b10 : 2'b00);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sb_ex       <= '0;
      sb_mem_vld  <= 1'b0;
      sb_mem_dest <= '0;
      sb_wb_vld   <= 1'b0;
      fwd_a       <= 2'b00;
      fwd_b       <= 2'b00;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      sb_wb_vld   <= sb_mem_vld;
      sb_mem_vld  <= sb_ex.vld;
      sb_mem_dest <= sb_ex.dest;
      sb_ex       <= '{vld:     rf_valid & rf_wren & ~stall_raw & ~flush,
                       dest:    rf_dest,
                       is_load: rf_memtoreg};
      if ((FORWARD_EN != 0) && !(stall_raw || flush)) begin
        fwd_a <= fsel(hit_ex[0], hit_mem[0]);
        fwd_b <= fsel(hit_ex[1], hit_mem[1]);
      end else begin
        fwd_a <= 2'b00;
        fwd_b <= 2'b00;
      end
      if (stall && !draining && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && !draining && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          halted <= 1'b0;
          if (halt_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!halt_req) begin
            state <= RUN;
          end else if (sb_empty && !rf_valid) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          if (!halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench: stimulus queues expected values tagged by cycle,
// a negedge monitor pops and compares them against both DUT configurations.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b0, rst_il = 1'b0;
  logic rf_valid = 0, rf_use_rs = 0, rf_use_rt = 0, rf_wren = 0, rf_memtoreg = 0;
  logic [4:0] rf_rs = 0, rf_rt = 0, rf_dest = 0;
  logic ex_taken = 0, halt_req = 0;

  logic pc_hold, ifrf_hold, ifrf_flush, rfex_bubble, halted;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic il_pc_hold, il_ifrf_hold, il_ifrf_flush, il_rfex_bubble, il_halted;
  logic [1:0] il_fwd_a, il_fwd_b;
  logic [1:0] il_stall_cnt, il_flush_cnt;

  pipeline_hazard_ctrl #(.FORWARD_EN(1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .rf_valid(rf_valid), .rf_rs(rf_rs), .rf_rt(rf_rt),
    .rf_use_rs(rf_use_rs), .rf_use_rt(rf_use_rt), .rf_wren(rf_wren), .rf_dest(rf_dest),
    .rf_memtoreg(rf_memtoreg), .ex_taken(ex_taken), .halt_req(halt_req),
    .pc_hold(pc_hold), .ifrf_hold(ifrf_hold), .ifrf_flush(ifrf_flush),
    .rfex_bubble(rfex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_hazard_ctrl #(.FORWARD_EN(0), .CNT_W(2)) dut_il (
    .clk(clk), .reset(rst_il), .rf_valid(rf_valid), .rf_rs(rf_rs), .rf_rt(rf_rt),
    .rf_use_rs(rf_use_rs), .rf_use_rt(rf_use_rt), .rf_wren(rf_wren), .rf_dest(rf_dest),
    .rf_memtoreg(rf_memtoreg), .ex_taken(ex_taken), .halt_req(halt_req),
    .pc_hold(il_pc_hold), .ifrf_hold(il_ifrf_hold), .ifrf_flush(il_ifrf_flush),
    .rfex_bubble(il_rfex_bubble), .fwd_a(il_fwd_a), .fwd_b(il_fwd_b), .halted(il_halted),
    .stall_cnt(il_stall_cnt), .flush_cnt(il_flush_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int S_CTRL = 0, S_FA = 1, S_FB = 2, S_HALT = 3, S_SCNT = 4, S_FCNT = 5;
  localparam int S_ILCTRL = 10, S_ILFA = 11, S_ILSCNT = 14;

  typedef struct {
    int          cyc;
    int          sel;
    logic [15:0] val;
    string       nm;
  } exp_t;
  exp_t q[$];
  int n_cmp = 0, n_bad = 0;

  // ctrl nibble = {pc_hold, ifrf_hold, ifrf_flush, rfex_bubble}
  function automatic logic [15:0] act(input int sel);
    case (sel)
      S_CTRL:   return {12'd0, pc_hold, ifrf_hold, ifrf_flush, rfex_bubble};
      S_FA:     return {14'd0, fwd_a};
      S_FB:     return {14'd0, fwd_b};
      S_HALT:   return {15'd0, halted};
      S_SCNT:   return stall_cnt;
      S_FCNT:   return flush_cnt;
      S_ILCTRL: return {12'd0, il_pc_hold, il_ifrf_hold, il_ifrf_flush, il_rfex_bubble};
      S_ILFA:   return {14'd0, il_fwd_a};
      S_ILSCNT: return {14'd0, il_stall_cnt};
      default:  return 16'hdead;
    endcase
  endfunction

  task automatic chk(input int dly, input int sel, input logic [15:0] val, input string nm);
    exp_t e;
    e.cyc = cyc + dly; e.sel = sel; e.val = val; e.nm = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    int i;
    logic [15:0] a;
    i = 0;
    while (i < q.size()) begin
      if (q[i].cyc <= cyc) begin
        a = act(q[i].sel);
        n_cmp++;
        if (q[i].cyc < cyc) begin
          n_bad++;
          $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", q[i].nm, q[i].cyc, cyc);
        end else if (a !== q[i].val) begin
          n_bad++;
          $display("FAIL %s: got %0h want %0h (cycle %0d)", q[i].nm, a, q[i].val, cyc);
        end
        q.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic drv(input logic v, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt, input logic we,
                     input logic [4:0] dst, input logic ld, input logic tk, input logic hr);
    @(posedge clk); #1;
    rf_valid = v; rf_rs = rs; rf_use_rs = urs; rf_rt = rt; rf_use_rt = urt;
    rf_wren = we; rf_dest = dst; rf_memtoreg = ld; ex_taken = tk; halt_req = hr;
  endtask

  task automatic idle(input logic hr);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, hr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset held with taken/halt asserted: outputs must stay 0
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk(0, S_CTRL, 0, "rst_ctrl"); chk(0, S_HALT, 0, "rst_halted");
    chk(0, S_FA, 0, "rst_fwd_a");  chk(0, S_FB, 0, "rst_fwd_b");
    chk(0, S_SCNT, 0, "rst_stall_cnt"); chk(0, S_FCNT, 0, "rst_flush_cnt");
    idle(0);

    // T1: add $3 then reader of $3 -> EX forward; next reader of $3 in rt -> MEM forward
    drv(1, 0, 0, 0, 0, 1, 3, 0, 0, 0); reset = 1'b1;
    drv(1, 3, 1, 7, 1, 0, 0, 0, 0, 0);
    chk(0, S_CTRL, 0, "t1_nostall"); chk(1, S_FA, 1, "t1_fwd_a_ex"); chk(1, S_FB, 0, "t1_fwd_b_none");
    drv(1, 0, 0, 3, 1, 0, 0, 0, 0, 0);
    chk(1, S_FB, 2, "t1_fwd_b_mem"); chk(1, S_FA, 0, "t1_fwd_a_unused");
    idle(0);

    // T2: lw $4 then rt=$4 -> one stall cycle, then MEM forward
    drv(1, 0, 0, 0, 0, 1, 4, 1, 0, 0);
    drv(1, 0, 1, 4, 1, 1, 9, 0, 0, 0);
    chk(0, S_CTRL, 4'b1101, "t2_stall"); chk(1, S_SCNT, 1, "t2_stall_cnt"); chk(1, S_FB, 0, "t2_fwd_b_stall");
    drv(1, 0, 1, 4, 1, 1, 9, 0, 0, 0);
    chk(0, S_CTRL, 0, "t2_release"); chk(1, S_FB, 2, "t2_fwd_b_mem"); chk(1, S_FA, 0, "t2_fwd_a_r0");
    idle(0);

    // T3: lw $0 then reads of $0 -> nothing
    drv(1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    drv(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    chk(0, S_CTRL, 0, "t3_r0_nostall"); chk(1, S_FA, 0, "t3_fwd_a"); chk(1, S_FB, 0, "t3_fwd_b");
    chk(1, S_SCNT, 1, "t3_stall_cnt_hold");
    idle(0);

    // T5: load-use coinciding with a taken branch -> flush only; wrong-path dest discarded
    drv(1, 0, 0, 0, 0, 1, 6, 1, 0, 0);
    drv(1, 6, 1, 0, 0, 1, 8, 0, 1, 0);
    chk(0, S_CTRL, 4'b0011, "t5_flush"); chk(1, S_FCNT, 1, "t5_flush_cnt");
    chk(1, S_SCNT, 1, "t5_stall_cnt_hold"); chk(1, S_FA, 0, "t5_fwd_a_flush");
    drv(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    chk(0, S_CTRL, 0, "t5_after"); chk(1, S_FA, 0, "t5_discarded");
    idle(0);

    // T6: three in flight, halt, drain, halted, release
    drv(1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 11, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 1, 12, 0, 0, 0);
    idle(1);
    chk(0, S_CTRL, 0, "t6_run"); chk(1, S_CTRL, 4'b1010, "t6_drain_ctrl");
    chk(1, S_HALT, 0, "t6_drain1"); chk(2, S_HALT, 0, "t6_drain2"); chk(3, S_HALT, 0, "t6_drain3");
    chk(4, S_HALT, 1, "t6_halted"); chk(4, S_CTRL, 4'b1010, "t6_halted_ctrl");
    repeat (4) idle(1);
    idle(0);
    chk(0, S_HALT, 1, "t6_still_halted"); chk(1, S_HALT, 0, "t6_resume");
    chk(1, S_CTRL, 0, "t6_resume_ctrl"); chk(1, S_SCNT, 1, "t6_stall_cnt_hold");
    idle(0);

    // reset asserted mid-drain clears everything at once
    drv(1, 0, 0, 0, 0, 1, 13, 0, 0, 1);
    idle(1);
    chk(0, S_CTRL, 4'b1010, "rd_draining");
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); reset = 1'b0;
    chk(0, S_CTRL, 0, "rd_ctrl"); chk(0, S_HALT, 0, "rd_halted");
    chk(0, S_SCNT, 0, "rd_stall_cnt"); chk(0, S_FCNT, 0, "rd_flush_cnt");
    chk(0, S_FA, 0, "rd_fwd_a"); chk(0, S_FB, 0, "rd_fwd_b");

    // T4: interlock-only instance: add $5 then use -> 2 stalls; then saturation at 3
    drv(1, 0, 0, 0, 0, 1, 5, 0, 0, 0); reset = 1'b1; rst_il = 1'b1;
    drv(1, 5, 1, 0, 0, 1, 14, 0, 0, 0);
    chk(0, S_ILCTRL, 4'b1101, "t4_stall1"); chk(0, S_CTRL, 0, "t4_fwd_cfg_nostall");
    chk(1, S_FA, 1, "t4_fwd_cfg_fwd_a");
    drv(1, 5, 1, 0, 0, 1, 14, 0, 0, 0);
    chk(0, S_ILCTRL, 4'b1101, "t4_stall2"); chk(1, S_ILSCNT, 2, "t4_stall_cnt2");
    drv(1, 5, 1, 0, 0, 1, 14, 0, 0, 0);
    chk(0, S_ILCTRL, 0, "t4_release"); chk(1, S_ILFA, 0, "t4_il_fwd_a");
    drv(1, 0, 0, 14, 1, 0, 0, 0, 0, 0);
    chk(0, S_ILCTRL, 4'b1101, "t4_sat_stall1"); chk(1, S_ILSCNT, 3, "t4_stall_cnt3");
    drv(1, 0, 0, 14, 1, 0, 0, 0, 0, 0);
    chk(0, S_ILCTRL, 4'b1101, "t4_sat_stall2"); chk(1, S_ILSCNT, 3, "t4_saturated");
    drv(1, 0, 0, 14, 1, 0, 0, 0, 0, 0);
    chk(0, S_ILCTRL, 0, "t4_sat_release"); chk(0, S_ILSCNT, 3, "t4_sat_hold");
    idle(0);

    repeat (2) @(posedge clk);
    #6;
    if (q.size() != 0) begin
      n_cmp += q.size();
      n_bad += q.size();
      $display("FAIL leftover: %0d expectations not sampled, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
